// File: rtl/llc_rst_flush_walker.sv
// llc_rst_flush_walker
// Set-walk sequencer in front of the LLC register block. On a reset stall or an
// accepted flush request it offers one walk token per set to the lookup pipeline.
// A credit counter caps in-flight tokens. The walk drains the completions and
// then pulses the matching stall-clear.
module llc_rst_flush_walker #(
  parameter  int LLC_SETS        = 256,
  parameter  int MAX_OUTSTANDING = 2,
  localparam int SET_BITS        = $clog2(LLC_SETS),
  localparam int CNT_BITS        = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_rst_state,
  input  logic                i_rst_stall,
  input  logic                i_flush_stall,
  input  logic [SET_BITS-1:0] i_rst_flush_stalled_set,
  input  logic                i_flush_req,
  output logic                o_flush_ack,
  output logic                o_walk_valid,
  input  logic                i_walk_ready,
  output logic [SET_BITS-1:0] o_walk_set,
  output logic                o_walk_is_flush,
  input  logic                i_walk_done,
  output logic                o_incr_rst_flush_stalled_set,
  output logic                o_clr_rst_flush_stalled_set,
  output logic                o_set_flush_stall,
  output logic                o_clr_rst_stall,
  output logic                o_clr_flush_stall,
  output logic                o_busy,
  output logic [CNT_BITS-1:0] o_outstanding,
  output logic                o_err_spurious_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WALK  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_is_flush;
  logic                w_is_flush_nxt;
  logic [CNT_BITS-1:0] r_outstanding;
  logic [CNT_BITS-1:0] w_outstanding_nxt;
  logic                r_err_spurious;

  logic w_quiet;
  logic w_walk_valid;
  logic w_accept;
  logic w_last_set;
  logic w_done_ok;
  logic w_spurious;
  logic w_flush_ack;
  logic w_clr_set;
  logic w_clr_rst;
  logic w_clr_flush;

  // Reset and soft reset both silence every pulse in the cycle they are seen.
  assign w_quiet      = i_rst | i_rst_state;
  // Tokens are offered only while credits remain; nothing else withdraws a token.
  assign w_walk_valid = (r_state == ST_WALK) &&
                        (r_outstanding < CNT_BITS'(MAX_OUTSTANDING)) && !w_quiet;
  assign w_accept     = w_walk_valid & i_walk_ready;
  assign w_last_set   = (i_rst_flush_stalled_set == SET_BITS'(LLC_SETS - 1));
  assign w_done_ok    = i_walk_done && (r_outstanding != CNT_BITS'(0));
  assign w_spurious   = i_walk_done && (r_outstanding == CNT_BITS'(0));

  // Next-state and pulse decode for the walk sequencer.
  always_comb begin
    w_state_nxt    = r_state;
    w_is_flush_nxt = r_is_flush;
    w_flush_ack    = 1'b0;
    w_clr_set      = 1'b0;
    w_clr_rst      = 1'b0;
    w_clr_flush    = 1'b0;
    if (w_quiet) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_rst_stall) begin
            // A reset walk always wins over a pending flush.
            w_state_nxt    = ST_WALK;
            w_is_flush_nxt = 1'b0;
          end else if (i_flush_req && !i_flush_stall) begin
            // A flush already stalled in the register block is still owned
            // by a walk, so it is not re-armed here.
            w_flush_ack    = 1'b1;
            w_state_nxt    = ST_WALK;
            w_is_flush_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_WALK: begin
          if (w_accept && w_last_set) begin
            w_state_nxt = ST_DRAIN;
          end else begin
            w_state_nxt = ST_WALK;
          end
        end
        ST_DRAIN: begin
          if ((r_outstanding == CNT_BITS'(0)) ||
              ((r_outstanding == CNT_BITS'(1)) && i_walk_done)) begin
            w_state_nxt = ST_FIN;
          end else begin
            w_state_nxt = ST_DRAIN;
          end
        end
        ST_FIN: begin
          w_clr_set   = 1'b1;
          w_clr_rst   = !r_is_flush;
          w_clr_flush = r_is_flush;
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Credit counter: +1 per accepted token, -1 per completion, floored at zero.
  always_comb begin
    w_outstanding_nxt = r_outstanding;
    case ({w_accept, w_done_ok})
      2'b10:   w_outstanding_nxt = r_outstanding + CNT_BITS'(1);
      2'b01:   w_outstanding_nxt = r_outstanding - CNT_BITS'(1);
      default: w_outstanding_nxt = r_outstanding;
    endcase
  end

  // State, mode, credit and sticky error registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_is_flush     <= 1'b0;
      r_outstanding  <= CNT_BITS'(0);
      r_err_spurious <= 1'b0;
    end else if (i_rst_state) begin
      // Abort the walk; in-flight tokens are dropped by the pipeline, and the
      // error flag survives so a soft reset cannot hide a protocol fault.
      r_state        <= ST_IDLE;
      r_is_flush     <= 1'b0;
      r_outstanding  <= CNT_BITS'(0);
      r_err_spurious <= r_err_spurious;
    end else begin
      r_state        <= w_state_nxt;
      r_is_flush     <= w_is_flush_nxt;
      r_outstanding  <= w_outstanding_nxt;
      r_err_spurious <= r_err_spurious | w_spurious;
    end
  end

  assign o_flush_ack                  = w_flush_ack;
  assign o_set_flush_stall            = w_flush_ack;
  assign o_walk_valid                 = w_walk_valid;
  assign o_walk_set                   = i_rst_flush_stalled_set;
  assign o_walk_is_flush              = w_walk_valid & r_is_flush;
  assign o_incr_rst_flush_stalled_set = w_accept;
  assign o_clr_rst_flush_stalled_set  = w_clr_set;
  assign o_clr_rst_stall              = w_clr_rst;
  assign o_clr_flush_stall            = w_clr_flush;
  assign o_busy                       = (r_state != ST_IDLE);
  assign o_outstanding                = r_outstanding;
  assign o_err_spurious_done          = r_err_spurious;

endmodule
